// File: rtl/sub_multiword_seq.sv
// sub_multiword_seq: multi-precision unsigned subtractor that reuses one 16-bit
// subtract-with-borrow stage across WORDS limbs, LSW first, chaining the borrow.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   a, b                  minuend / subtrahend, 16*WORDS bits, unsigned
//   out_valid / out_ready result handshake (valid only while done)
//   result                (a - b) mod 2^(16*WORDS), built limb by limb
//   borrow                1 iff a < b
module sub_multiword_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   a,
   input  logic [16*WORDS-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   result,
   output logic                  borrow
);

   localparam int unsigned LIMB_W = 16;
   localparam int unsigned W      = LIMB_W * WORDS;
   localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               bint_q, bint_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       result_q, result_d;
   logic               borrow_q, borrow_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [LIMB_W-1:0]  a_limb, b_limb;
   logic [LIMB_W:0]    sub_res;

   // Select the current limb pair and run the shared 17-bit subtract stage.
   always_comb begin
      a_limb = '0;
      b_limb = '0;
      for (int unsigned k = 0; k < WORDS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_limb = a_q[k*LIMB_W +: LIMB_W];
            b_limb = b_q[k*LIMB_W +: LIMB_W];
         end
      end
      sub_res = {1'b0, a_limb} - {1'b0, b_limb} - (LIMB_W+1)'(bint_q);
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      bint_d   = bint_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      borrow_d = borrow_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               bint_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int unsigned k = 0; k < WORDS; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  result_d[k*LIMB_W +: LIMB_W] = sub_res[LIMB_W-1:0];
               end
            end
            bint_d = sub_res[LIMB_W];
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               borrow_d = sub_res[LIMB_W];
               idx_d    = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake flags follow the state being entered so they stay registered.
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset wins over every handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         bint_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         bint_q      <= bint_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         borrow_q    <= borrow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign borrow    = borrow_q;

endmodule
